b9_rr_seq: RTL and testbench
============================

Name: b9_rr_seq

Overview:
Parametrised, registered successor to the flat b9 control decoder. Arbitrates N_CH request channels round-robin and holds each grant until the channel signals done, drops its request, or hits a hold timeout. Also keeps a saturating grant count. Sits between the condition-decode logic, which drives req/mask, and the downstream strobe consumers.

Parameters:
N_CH, 4, number of request channels (2..16)
ID_W, 2, width of gnt_id; must be at least ceil(log2(N_CH))
MAX_HOLD, 8, maximum cycles a grant may stay in GRANT before forced release (2..255)
CNT_W, 4, width of the saturating grant counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
en  input  1  arbitration enable; sampled only in IDLE
req  input  N_CH  per-channel request, level
mask  input  N_CH  per-channel inhibit; 1 excludes the channel from arbitration
done  input  N_CH  per-channel completion strobe; only done[gnt_id] is honoured
gnt  output  N_CH  registered one-hot grant; all-zero when no grant
gnt_id  output  ID_W  index of the current/last granted channel
busy  output  1  1 while in GRANT or RELEASE
timeout  output  1  one-cycle pulse when a grant is force-released
gnt_cnt  output  CNT_W  number of grants issued, saturating

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, gnt_cnt=0, hold counter=0, last_id=N_CH-1 so channel 0 has first priority. Reset overrides everything, including mid-grant; gnt drops on the same edge.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - eligible = req & ~mask.
  - If en=1 and eligible!=0, select the first eligible index searching last_id+1, last_id+2, ... modulo N_CH.
  - Next edge: state=GRANT, gnt=onehot(sel), gnt_id=sel, busy=1, hold=0, gnt_cnt+=1 (saturating at 2^CNT_W-1).
  - Otherwise remain IDLE with gnt=0.
- Latency: req asserted before edge t while IDLE → gnt visible after edge t (1 cycle).
- GRANT, checked each edge in priority order:
  - done[gnt_id]=1 or req[gnt_id]=0: go to RELEASE, gnt=0, no timeout.
  - Else if hold==MAX_HOLD-1: go to RELEASE, gnt=0, timeout=1 for that one cycle.
  - Else hold+=1.
  - Grant lifetime is therefore at most MAX_HOLD cycles.
  - If done and the timeout condition coincide, done wins and no timeout is raised.
- GRANT ignores: en, mask changes, and done on other channels. Done on other channels is dropped, not queued.
- RELEASE: exactly one cycle with gnt=0 and busy=1. last_id:=gnt_id. Next edge: IDLE, busy=0, timeout=0. A channel still requesting competes again but has lowest priority.
- gnt_id holds its last value through IDLE.
- Minimum spacing between grants is 3 cycles (GRANT≥1, RELEASE 1, IDLE 1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset with req=4'b1111, en=1 → after first edge out of reset gnt=0001, gnt_id=0, gnt_cnt=1; done[0] next cycle → gnt=0 and busy=1 for 1 cycle, then IDLE, then gnt=0010.
- Round-robin wrap: req=4'b1001 held, done pulsed each grant → grant order 0,3,0,3; gnt_cnt increments 1,2,3,4.
- Timeout: MAX_HOLD=8, req[2]=1, no done → gnt=0100 for exactly 8 cycles, timeout=1 for 1 cycle coincident with RELEASE, gnt_cnt=1.
- Done on final hold cycle (cycle 8) together with the timeout condition → RELEASE with timeout=0.
- Mask and enable: req=4'b0110, mask=4'b0010 → grant goes to ch2 only. en=0 in IDLE → gnt stays 0. en=0 during GRANT → the grant completes normally.
- Saturation and mid-grant reset: CNT_W=2, 5 grants → gnt_cnt=3. rst_n=0 during GRANT → next edge gnt=0, busy=0, gnt_cnt=0, and the next grant goes to channel 0.

Source files
------------

// File: rtl/b9_rr_seq.sv
// b9_rr_seq: round-robin grant sequencer.
// Arbitrates N_CH level requests, holds the grant until the owner signals
// done, drops its request, or runs out of hold time. Every output comes
// straight from a flop. A saturating counter tracks how many grants were issued.
module b9_rr_seq #(
    parameter int N_CH     = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  mask,
    input  logic [N_CH-1:0]  done,
    output logic [N_CH-1:0]  gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] gnt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // MAX_HOLD is at most 255, so an 8-bit hold counter always suffices.
    localparam int               HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = 8'd1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_CH-1:0]   GNT_ONE   = {{(N_CH-1){1'b0}}, 1'b1};
    // Reset points last_id at the top channel so channel 0 wins first.
    localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(N_CH - 1);

    // Round-robin pick: first eligible channel after 'last', wrapping.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_CH-1:0] elig,
        input logic [ID_W-1:0] last
    );
        logic            found;
        int              idx;
        logic [N_CH-1:0] shifted;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx     = (int'(last) + i) % N_CH;
            shifted = elig >> idx;
            if (!found && shifted[0]) begin
                found   = 1'b1;
                rr_pick = ID_W'(idx);
            end
        end
    endfunction

    state_e           state_q,   state_d;
    logic [N_CH-1:0]  gnt_q,     gnt_d;
    logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;

    logic [N_CH-1:0]  eligible_s;
    logic             any_elig_s;
    logic             start_s;
    logic [ID_W-1:0]  sel_s;
    logic             owner_done_s;
    logic             owner_drop_s;
    logic             hold_expired_s;

    // Shared decode: eligibility, winner, and end-of-grant conditions.
    // gnt_q is one-hot on the owner while granting, so masking with it
    // selects the owner's done/req bits without indexing by gnt_id.
    always_comb begin
        eligible_s     = req & ~mask;
        any_elig_s     = |eligible_s;
        start_s        = en & any_elig_s;
        sel_s          = rr_pick(eligible_s, last_id_q);
        owner_done_s   = |(done & gnt_q);
        owner_drop_s   = ~|(req & gnt_q);
        hold_expired_s = (hold_q == HOLD_LAST);
    end

    // Next-state logic for the IDLE/GRANT/RELEASE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (owner_done_s || owner_drop_s || hold_expired_s) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the hold/priority bookkeeping.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        gnt_cnt_d = gnt_cnt_q;
        hold_d    = hold_q;
        last_id_d = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    gnt_d    = GNT_ONE << sel_s;
                    gnt_id_d = sel_s;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                    if (gnt_cnt_q != CNT_MAX) begin
                        gnt_cnt_d = gnt_cnt_q + CNT_ONE;
                    end else begin
                        gnt_cnt_d = gnt_cnt_q;
                    end
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (owner_done_s || owner_drop_s) begin
                    // A normal finish beats a coincident hold expiry.
                    gnt_d  = '0;
                    busy_d = 1'b1;
                end else if (hold_expired_s) begin
                    gnt_d     = '0;
                    busy_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_RELEASE: begin
                // Released owner drops to lowest priority for the next pick.
                gnt_d     = '0;
                busy_d    = 1'b0;
                last_id_d = gnt_id_q;
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            gnt_cnt_q <= '0;
            hold_q    <= '0;
            last_id_q <= LAST_RST;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            gnt_cnt_q <= gnt_cnt_d;
            hold_q    <= hold_d;
            last_id_q <= last_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign gnt_cnt = gnt_cnt_q;

endmodule

// File: tb/tb_b9_rr_seq.sv
// Self-checking bench for b9_rr_seq: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_b9_rr_seq;

    localparam int N_CH     = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  mask;
    logic [N_CH-1:0]  done;
    logic [N_CH-1:0]  gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] gnt_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the grant, for how long, and bookkeeping.
    int m_owner;   // -1 when nobody holds a grant
    int m_age;     // cycles the owner has already held beyond the first
    int m_last;    // channel granted most recently (priority pointer)
    int m_cnt;
    int m_id;
    bit m_rel;     // in the one-cycle gap after a grant ends
    bit m_to;

    b9_rr_seq #(
        .N_CH(N_CH), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
        .done(done), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .timeout(timeout), .gnt_cnt(gnt_cnt)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs: {gnt, gnt_id, busy, timeout, gnt_cnt}.
    function automatic logic [11:0] pack_dut();
        return {gnt, gnt_id, busy, timeout, gnt_cnt};
    endfunction

    function automatic logic [11:0] pack_model();
        logic [3:0] g;
        logic [1:0] i;
        logic [3:0] c;
        logic       b;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        i = m_id[1:0];
        c = m_cnt[3:0];
        b = (m_owner >= 0) || m_rel;
        return {g, i, b, m_to, c};
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic [N_CH-1:0] elig;
        int c;
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_last = N_CH - 1; m_cnt = 0;
            m_id = 0; m_rel = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            elig = req & ~mask;
            if (m_rel) begin
                m_rel  = 1'b0;
                m_last = m_id;
            end else if (m_owner >= 0) begin
                if (done[m_owner[ID_W-1:0]] || !req[m_owner[ID_W-1:0]]) begin
                    m_owner = -1; m_rel = 1'b1;
                end else if (m_age == MAX_HOLD - 1) begin
                    m_owner = -1; m_rel = 1'b1; m_to = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (en && elig != 4'b0000) begin
                for (int k = 1; k <= N_CH; k++) begin
                    c = (m_last + k) % N_CH;
                    if (elig[c[ID_W-1:0]]) begin
                        m_owner = c; m_id = c; m_age = 0;
                        if (m_cnt < CNT_MAX) m_cnt++;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; req = '0; mask = '0; done = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst_n = 1'b0; en = 1'b1; req = 4'b1111; mask = '0; done = '0;
        tick();
        e = {4'b0000, 2'd0, 1'b0, 1'b0, 4'd0};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL reset_state got=%b exp=%b", pack_dut(), e); end
        rst_n = 1'b1;
        tick();
        e = {4'b0001, 2'd0, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL first_grant got=%b exp=%b", pack_dut(), e); end
        done = 4'b0001;
        tick();
        done = '0;
        e = {4'b0000, 2'd0, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL release_cycle got=%b exp=%b", pack_dut(), e); end
        tick();
        e = {4'b0000, 2'd0, 1'b0, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL idle_gap got=%b exp=%b", pack_dut(), e); end
        tick();
        e = {4'b0010, 2'd1, 1'b1, 1'b0, 4'd2};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL second_grant got=%b exp=%b", pack_dut(), e); end
    endtask

    task automatic test_rr_wrap();
        logic [11:0] e;
        logic [3:0]  eg;
        logic [3:0]  ec;
        logic [1:0]  ei;
        int          ch;
        do_reset();
        req = 4'b1001; en = 1'b1;
        for (int g = 0; g < 4; g++) begin
            ch = (g % 2 == 0) ? 0 : 3;
            eg = 4'b0001 << ch;
            ei = ch[1:0];
            ec = 4'(g + 1);
            tick();
            e = {eg, ei, 1'b1, 1'b0, ec};
            total++; if (pack_dut() !== e) begin bad++; $display("FAIL rr_wrap_%0d got=%b exp=%b", g, pack_dut(), e); end
            done = eg;
            tick();
            done = '0;
            tick();
        end
        req = '0;
    endtask

    task automatic test_timeout();
        logic [11:0] e;
        do_reset();
        req = 4'b0100; en = 1'b1;
        tick();
        e = {4'b0100, 2'd2, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL to_grant got=%b exp=%b", pack_dut(), e); end
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            total++; if (pack_dut() !== e) begin bad++; $display("FAIL to_hold_%0d got=%b exp=%b", i, pack_dut(), e); end
        end
        tick();
        e = {4'b0000, 2'd2, 1'b1, 1'b1, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL to_pulse got=%b exp=%b", pack_dut(), e); end
        req = '0;
        tick();
        e = {4'b0000, 2'd2, 1'b0, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL to_after got=%b exp=%b", pack_dut(), e); end
    endtask

    task automatic test_done_last();
        logic [11:0] e;
        do_reset();
        req = 4'b0100; en = 1'b1;
        tick();
        for (int i = 1; i < MAX_HOLD; i++) tick();
        e = {4'b0100, 2'd2, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL dl_last_hold got=%b exp=%b", pack_dut(), e); end
        done = 4'b0100;
        tick();
        done = '0; req = '0;
        e = {4'b0000, 2'd2, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL done_wins got=%b exp=%b", pack_dut(), e); end
        tick();
    endtask

    task automatic test_mask_en();
        logic [11:0] e;
        do_reset();
        req = 4'b0110; mask = 4'b0010; en = 1'b1;
        tick();
        e = {4'b0100, 2'd2, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL mask_grant got=%b exp=%b", pack_dut(), e); end
        req = '0;
        tick();
        e = {4'b0000, 2'd2, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL req_drop_rel got=%b exp=%b", pack_dut(), e); end
        en = 1'b0; req = 4'b1111; mask = '0;
        tick();
        tick();
        e = {4'b0000, 2'd2, 1'b0, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL en_off_idle got=%b exp=%b", pack_dut(), e); end
        en = 1'b1;
        tick();
        e = {4'b1000, 2'd3, 1'b1, 1'b0, 4'd2};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL en_on_grant got=%b exp=%b", pack_dut(), e); end
        en = 1'b0; mask = 4'b1111; done = 4'b0001;
        tick();
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL grant_ignores got=%b exp=%b", pack_dut(), e); end
        done = 4'b1000;
        tick();
        done = '0;
        e = {4'b0000, 2'd3, 1'b1, 1'b0, 4'd2};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL en_off_done got=%b exp=%b", pack_dut(), e); end
        tick();
        e = {4'b0000, 2'd3, 1'b0, 1'b0, 4'd2};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL en_off_back got=%b exp=%b", pack_dut(), e); end
        mask = '0; req = '0;
    endtask

    task automatic test_sat_reset();
        logic [11:0] e;
        logic [3:0]  eg;
        logic [3:0]  ec;
        logic [1:0]  ei;
        int          ch;
        do_reset();
        req = 4'b1111; en = 1'b1;
        for (int g = 0; g < 19; g++) begin
            ch = g % N_CH;
            eg = 4'b0001 << ch;
            ei = ch[1:0];
            ec = (g + 1 > CNT_MAX) ? 4'(CNT_MAX) : 4'(g + 1);
            tick();
            e = {eg, ei, 1'b1, 1'b0, ec};
            total++; if (pack_dut() !== e) begin bad++; $display("FAIL sat_%0d got=%b exp=%b", g, pack_dut(), e); end
            if (g < 18) begin
                done = eg;
                tick();
                done = '0;
                tick();
            end
        end
        rst_n = 1'b0;
        tick();
        e = {4'b0000, 2'd0, 1'b0, 1'b0, 4'd0};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL mid_reset got=%b exp=%b", pack_dut(), e); end
        rst_n = 1'b1;
        tick();
        e = {4'b0001, 2'd0, 1'b1, 1'b0, 4'd1};
        total++; if (pack_dut() !== e) begin bad++; $display("FAIL post_reset got=%b exp=%b", pack_dut(), e); end
    endtask

    task automatic test_random();
        logic [11:0] e;
        do_reset();
        req = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            done  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            tick();
            e = pack_model();
            total++; if (pack_dut() !== e) begin bad++; $display("FAIL random_%0d got=%b exp=%b", cyc, pack_dut(), e); end
        end
        rst_n = 1'b1; done = '0;
    endtask

    initial begin
        test_reset();
        test_rr_wrap();
        test_timeout();
        test_done_last();
        test_mask_en();
        test_sat_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
